// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Pure declarations; no logic or state.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] IMEM_BASE      = 32'h0;

  // Byte address of instruction word idx.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return IMEM_BASE + (idx << 2);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in (valid/ready) and instruction-memory write port out.
// slave = loader side, master = upstream source / memory side.
interface program_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word/word_valid are valid in the 4th-byte cycle.
// Zero latency on the completing byte; stalls (en low) hold index and partial word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx_q;
  logic [23:0]      low_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      low_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      low_q <= '0;
    end else if (en) begin
      idx_q <= idx_q + 1'b1;
      case (idx_q)
        2'd0:    low_q[7:0]   <= din;
        2'd1:    low_q[15:8]  <= din;
        2'd2:    low_q[23:16] <= din;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word is usable on the completing cycle.
  assign word       = {din, low_q};
  assign word_valid = en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, verifies an XOR checksum, then releases core reset.
// imem write one cycle after each 4th byte; accepts one byte per cycle in LOAD/CHECK, never stalls on writes.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_words,
  program_loader_if.slave       bus,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] word_cnt_q;
  logic [31:0]         csum_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;

  logic        accept;
  logic        len_ok;
  logic        load_go;
  logic [31:0] word;
  logic        word_valid;

  assign accept = bus.byte_valid & bus.byte_ready;
  assign len_ok = (load_words != '0) && (load_words <= MAX_WORDS);

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_go),
    .en         (accept),
    .din        (bus.byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    load_go = 1'b0;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          if (len_ok) begin
            state_d = LOAD;
            load_go = 1'b1;
          end else begin
            state_d = ERROR;
          end
        end
      end
      LOAD: begin
        if (word_valid && ((word_cnt_q + 1'b1) == len_q)) state_d = CHECK;
      end
      CHECK: begin
        if (word_valid) state_d = (word == csum_q) ? RUN : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Checksum and word index advance on the completing byte, so the last word is folded in before CHECK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (load_go) begin
        len_q      <= load_words;
        word_cnt_q <= '0;
        csum_q     <= '0;
      end else if (state_q == LOAD && word_valid) begin
        we_q       <= 1'b1;
        addr_q     <= word_addr(32'(word_cnt_q));
        wdata_q    <= word;
        csum_q     <= csum_q ^ word;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign bus.byte_ready = (state_q == LOAD) || (state_q == CHECK);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q == LOAD) || (state_q == CHECK);
  assign done           = (state_q == RUN);
  assign error          = (state_q == ERROR);
  assign core_reset     = (state_q != RUN);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] load_words = '0;
  logic       core_reset;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader_if bus();

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_words (load_words),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Every high imem_we cycle is logged; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (reset && bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 20) begin
      acc = bus.byte_ready;
      tick();
      t++;
    end
    if (!acc) check("byte_accept_timeout", 32'(acc), 32'd1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic do_start(input logic [8:0] n);
    start      = 1'b1;
    load_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_wr();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    if (i < wr_addr.size()) begin
      check({tag, "_addr"}, wr_addr[i], a);
      check({tag, "_data"}, wr_data[i], d);
    end else begin
      check({tag, "_missing"}, 32'(wr_addr.size()), 32'(i + 1));
    end
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_core_reset"}, 32'(core_reset),     32'd1);
    check({p, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({p, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check({p, "_imem_addr"},  bus.imem_addr,       32'd0);
    check({p, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    check({p, "_busy"},       32'(busy),           32'd0);
    check({p, "_done"},       32'(done),           32'd0);
    check({p, "_error"},      32'(error),          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Zero-length start from IDLE goes straight to ERROR; no bytes taken
    do_start(9'd0);
    check("len0_error", 32'(error), 32'd1);
    check("len0_busy",  32'(busy),  32'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5a;
    for (int i = 0; i < 3; i++) begin
      check("len0_no_ready", 32'(bus.byte_ready), 32'd0);
      tick();
    end
    bus.byte_valid = 1'b0;

    // Good 2-word load
    clear_wr();
    do_start(9'd2);
    check("t1_busy",       32'(busy),           32'd1);
    check("t1_ready",      32'(bus.byte_ready), 32'd1);
    check("t1_core_reset", 32'(core_reset),     32'd1);
    send_word(32'h0000_0013, 0);
    check("t1_we0",    32'(bus.imem_we), 32'd1);
    check("t1_wdata0", bus.imem_wdata,   32'h0000_0013);
    send_word(32'h0010_0093, 0);
    check("t1_we_last",   32'(bus.imem_we), 32'd1);
    check("t1_check_bsy", 32'(busy),        32'd1);
    send_word(32'h0010_0080, 0);
    check("t1_done",       32'(done),       32'd1);
    check("t1_core_reset", 32'(core_reset), 32'd0);
    check("t1_busy_run",   32'(busy),       32'd0);
    check("t1_err",        32'(error),      32'd0);
    check("t1_wr_n", 32'(wr_addr.size()), 32'd2);
    check_wr("t1_wr0", 0, 32'd0, 32'h0000_0013);
    check_wr("t1_wr1", 1, 32'd4, 32'h0010_0093);

    // Bytes offered in RUN are not consumed
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hff;
    for (int i = 0; i < 3; i++) begin
      check("run_no_ready", 32'(bus.byte_ready), 32'd0);
      tick();
    end
    bus.byte_valid = 1'b0;
    check("run_hold_done", 32'(done), 32'd1);

    // Oversized length from RUN
    do_start(9'd257);
    check("len257_error",      32'(error),      32'd1);
    check("len257_done",       32'(done),       32'd0);
    check("len257_core_reset", 32'(core_reset), 32'd1);

    // Bad checksum
    clear_wr();
    do_start(9'd2);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0000_0000, 0);
    check("t2_error",      32'(error),      32'd1);
    check("t2_core_reset", 32'(core_reset), 32'd1);
    check("t2_done",       32'(done),       32'd0);
    repeat (3) tick();
    check("t2_wr_n", 32'(wr_addr.size()), 32'd2);

    // 3-word load with stalls between bytes
    clear_wr();
    do_start(9'd3);
    send_word(32'h1122_3344, 3 + $urandom_range(0, 2));
    send_word(32'h0a0b_0c0d, 3 + $urandom_range(0, 2));
    send_word(32'hdead_beef, 3 + $urandom_range(0, 2));
    send_word(32'hc584_81a6, 3 + $urandom_range(0, 2));
    check("t3_done", 32'(done), 32'd1);
    check("t3_wr_n", 32'(wr_addr.size()), 32'd3);
    check_wr("t3_wr0", 0, 32'd0, 32'h1122_3344);
    check_wr("t3_wr1", 1, 32'd4, 32'h0a0b_0c0d);
    check_wr("t3_wr2", 2, 32'd8, 32'hdead_beef);

    // Reload from RUN
    clear_wr();
    do_start(9'd1);
    check("t4_core_reset", 32'(core_reset), 32'd1);
    check("t4_done",       32'(done),       32'd0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0000_0013, 0);
    check("t4_done_again", 32'(done),       32'd1);
    check("t4_core_rel",   32'(core_reset), 32'd0);
    check("t4_wr_n", 32'(wr_addr.size()), 32'd1);
    check_wr("t4_wr0", 0, 32'd0, 32'h0000_0013);

    // Async reset after 6 bytes, then a fresh load
    do_start(9'd2);
    send_word(32'h0000_0013, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    clear_wr();
    do_start(9'd2);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0010_0080, 0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_wr_n", 32'(wr_addr.size()), 32'd2);
    check_wr("t5_wr0", 0, 32'd0, 32'h0000_0013);
    check_wr("t5_wr1", 1, 32'd4, 32'h0010_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V datapath. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the instruction memory, verifies an XOR checksum, and only then releases the datapath's reset. This replaces `$readmemb` preloading for synthesizable boot.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory word-address width; depth = 2^ADDR_WIDTH words
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  level-sampled request to begin a load
- `load_words`  in  ADDR_WIDTH+1  program length in words, sampled on the accepting `start` cycle
- `byte_valid`  in  1  upstream byte present
- `byte_data`  in  8  upstream byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word
- `imem_addr`  out  32  byte address of the word being written: word index × 4, base 0
- `imem_wdata`  out  32  assembled instruction word
- `core_reset`  out  1  active-high reset to the datapath `reset` input
- `busy`  out  1  high in LOAD and CHECK
- `done`  out  1  high in RUN
- `error`  out  1  high in ERROR

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERROR. A byte is accepted only when `byte_valid & byte_ready`.
- IDLE:
  - `start` with 1 ≤ `load_words` ≤ 2^ADDR_WIDTH → LOAD. Latch the length; clear the word index, byte index and checksum.
  - `start` with `load_words` = 0 or > 2^ADDR_WIDTH → ERROR.
- LOAD: `byte_ready` = 1. Byte k of a word (k = 0..3) lands in bits [8k+7:8k].
  - On the 4th accepted byte, the next cycle drives `imem_we` = 1 with `imem_addr` = word_index×4 and `imem_wdata` = the word.
  - In the same cycle, checksum ^= word and word_index++.
  - The 4th byte of the final word moves the FSM to CHECK.
- CHECK: `byte_ready` = 1. Collect 4 bytes, little-endian, and compare against the checksum. Equal → RUN; otherwise → ERROR. `imem_we` stays 0.
- RUN: `core_reset` = 0, `done` = 1. `start` reloads, following the IDLE rules, and `core_reset` reasserts on the transition edge.
- ERROR: `core_reset` = 1, `error` = 1. `start` follows the IDLE rules.
- `start` is ignored in LOAD and CHECK.
- `byte_ready` = 0 in IDLE, RUN and ERROR. Bytes presented in those states are not consumed.
- Checksum width is 32 bits, XOR only, with no carry.

## Timing
- Reset values: state IDLE, `core_reset` = 1, `byte_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `busy` = 0, `done` = 0, `error` = 0, all counters 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `byte_valid`/`byte_data` to any output.
- Throughput is one byte per cycle. Stalls (`byte_valid` = 0) hold the byte index and the partial word unchanged.
- Write latency: `imem_we` rises exactly one cycle after the 4th-byte handshake. Byte acceptance continues during that write cycle, so writes never stall the stream.
- The FSM enters RUN on the edge after the last checksum byte is accepted; `core_reset` falls on that same edge.
- Minimum load of N words takes 4N+4 handshake cycles plus 1.
- The final word's `imem_we` pulse coincides with the first CHECK cycle and must still occur.
- Asserting `reset` mid-load immediately returns all outputs to their reset values. Memory contents already written are left as-is.

## Structure
- Shared package `loader_pkg`:
  - state encoding (IDLE=0, LOAD=1, CHECK=2, RUN=3, ERROR=4)
  - `BYTES_PER_WORD` = 4
  - `IMEM_BASE` = 32'h0
- Sub-module `word_assembler`: 2-bit byte index, 32-bit shift/insert register, and a `word_valid` pulse on the 4th byte. It is reused by both LOAD and CHECK.
- The top level holds the FSM, word counter, checksum register and the output registers.

## Test plan
- Load 2 words, bytes 13 00 00 00, 93 00 10 00, checksum bytes 80 00 10 00:
  - `imem_we` pulses at addr 0 with 0x00000013, then at addr 4 with 0x00100093.
  - Then RUN, `core_reset` = 0, `done` = 1.
- Same load with checksum 0x00000000 → ERROR, `core_reset` stays 1, `error` = 1, no third write.
- `start` with `load_words` = 0 → ERROR on the next cycle, `byte_ready` never asserts. Also `load_words` = 257 with ADDR_WIDTH = 8 → ERROR.
- Random `byte_valid` gaps (≥ 3-cycle stalls between bytes) during a 3-word load:
  - Identical words and addresses 0, 4, 8.
  - `imem_we` is exactly one cycle each.
- `reset` driven low after 6 bytes of a 2-word load:
  - All outputs take their reset values asynchronously.
  - A fresh `start` then reloads correctly from addr 0.
- In RUN, assert `start` with `load_words` = 1:
  - `core_reset` rises on that edge and `done` falls.
  - After 1 word plus checksum, RUN is re-entered.
